// File: rtl/bram_stream_reader_if.sv
// bram_stream_reader_if: RAM read port plus the outgoing valid/ready stream.
// master = reader side, slave = RAM model / downstream pixel logic side.
interface bram_stream_reader_if #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] ram_rd_addr;
   logic [DATA_WIDTH-1:0] ram_rd_data;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_ready;
   logic                  m_last;

   modport master (
      output ram_rd_addr,
      input  ram_rd_data,
      output m_data,
      output m_valid,
      output m_last,
      input  m_ready
   );

   modport slave (
      input  ram_rd_addr,
      output ram_rd_data,
      input  m_data,
      input  m_valid,
      input  m_last,
      output m_ready
   );
endinterface

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: burst read engine for a 1- or 2-cycle-latency block RAM.
// Issues reads under a credit rule so the FWFT output buffer can never
// overflow, and presents the words as a valid/ready stream with a last flag.
// Optional pattern checker enabled by defining BRAM_STREAM_READER_CHECK_EN.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; zero-length start only pulses done
// ISSUE  | issuing reads while occupancy + in-flight < BUF_DEPTH
// DRAIN  | all reads issued; waiting for the last word to be popped
module bram_stream_reader #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 8,
   parameter int RD_LATENCY = 1,
   parameter int BUF_DEPTH  = 4
) (
   input  logic                    rd_clk,
   input  logic                    rd_rst_n,
   input  logic                    start,
   input  logic [ADDR_WIDTH-1:0]   base_addr,
   input  logic [ADDR_WIDTH:0]     length,
   bram_stream_reader_if.master    bus,
   output logic                    busy,
   output logic                    done,
   output logic                    chk_err,
   output logic [7:0]              chk_err_cnt
);
   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);
   localparam logic [ADDR_WIDTH:0] LEN_ZERO = '0;
   localparam logic [ADDR_WIDTH:0] LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(BUF_DEPTH);

   if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
      $error("bram_stream_reader: RD_LATENCY must be 1 or 2");
   end
   if (BUF_DEPTH < RD_LATENCY + 1 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("bram_stream_reader: BUF_DEPTH must be a power of two >= RD_LATENCY+1");
   end

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   rd_addr;
   logic [ADDR_WIDTH:0]     issue_rem;
   logic [ADDR_WIDTH:0]     out_rem;
   logic [RD_LATENCY-1:0]   vld_pipe;
   logic [DATA_WIDTH-1:0]   mem [BUF_DEPTH];
   logic [PTR_W-1:0]        wr_ptr, rd_ptr;
   logic [CNT_W-1:0]        count;
   logic                    start_acc, issue, push, pop, empty, credit;

   // state register
   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) state <= S_IDLE;
      else           state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start && length != LEN_ZERO)  state_nxt = S_ISSUE;
         S_ISSUE: if (issue && issue_rem == LEN_ONE) state_nxt = S_DRAIN;
         S_DRAIN: if (pop && out_rem == LEN_ONE)     state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // outputs and handshake decode
   always_comb begin
      busy        = (state != S_IDLE);
      start_acc   = start && (state == S_IDLE);
      credit      = (int'(count) + $countones(vld_pipe)) < BUF_DEPTH;
      issue       = (state == S_ISSUE) && credit;
      push        = vld_pipe[RD_LATENCY-1];
      empty       = (count == '0);
      pop         = !empty && bus.m_ready;
      bus.m_valid = !empty;
      bus.m_data  = empty ? '0 : mem[rd_ptr];
      bus.m_last  = !empty && (out_rem == LEN_ONE);
   end

   assign bus.ram_rd_addr = rd_addr;

   // burst address, issue/output down-counters, done pulse
   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         rd_addr   <= '0;
         issue_rem <= '0;
         out_rem   <= '0;
         done      <= 1'b0;
      end else if (start_acc) begin
         if (length != LEN_ZERO) begin
            rd_addr   <= base_addr;
            issue_rem <= length;
            out_rem   <= length;
         end
         done <= (length == LEN_ZERO);
      end else begin
         if (issue) begin
            rd_addr   <= rd_addr + 1'b1;
            issue_rem <= issue_rem - LEN_ONE;
         end
         if (pop) out_rem <= out_rem - LEN_ONE;
         done <= pop && (out_rem == LEN_ONE);
      end
   end

   // in-flight pipe and buffer pointers
   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         vld_pipe <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         vld_pipe <= (vld_pipe << 1) | RD_LATENCY'(issue);
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // buffer storage; contents are don't-care while empty
   always_ff @(posedge rd_clk) begin
      if (push) mem[wr_ptr] <= bus.ram_rd_data;
   end

   a_no_overflow: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
      !(push && count == CNT_FULL));

`ifdef BRAM_STREAM_READER_CHECK_EN
   logic [DATA_WIDTH-1:0] chk_idx;

   // compare each popped word against the descending fill pattern
   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         chk_idx     <= '0;
         chk_err     <= 1'b0;
         chk_err_cnt <= '0;
      end else if (start_acc) begin
         chk_idx     <= '0;
         chk_err     <= 1'b0;
         chk_err_cnt <= '0;
      end else if (pop) begin
         chk_idx <= chk_idx + 1'b1;
         if (bus.m_data != ~chk_idx) begin
            chk_err <= 1'b1;
            if (chk_err_cnt != 8'hFF) chk_err_cnt <= chk_err_cnt + 8'd1;
         end
      end
   end
`else
   assign chk_err     = 1'b0;
   assign chk_err_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: directed bench with a table of bursts for the
// latency-1 reader plus hand sequences for wrap, backpressure on a latency-2
// reader, start-while-busy, mid-burst reset and the pattern checker.
module tb_bram_stream_reader;
   localparam int AW = 11;
   localparam int DW = 8;
`ifdef BRAM_STREAM_READER_CHECK_EN
   localparam int CHK_EXP = 1;
`else
   localparam int CHK_EXP = 0;
`endif

   logic          rd_clk = 1'b0;
   logic          rd_rst_n = 1'b0;
   logic          start1 = 1'b0, start2 = 1'b0;
   logic [AW-1:0] base1 = '0, base2 = '0;
   logic [AW:0]   len1 = '0, len2 = '0;
   logic          busy1, done1, chk_err1, busy2, done2, chk_err2;
   logic [7:0]    chk_cnt1, chk_cnt2;
   logic [DW-1:0] ram [2048];
   logic [DW-1:0] ram2_stage;

   int n_checks = 0;
   int n_errors = 0;

   bram_stream_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
   bram_stream_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

   bram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .BUF_DEPTH(4)) u_dut1 (
      .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .start(start1), .base_addr(base1), .length(len1),
      .bus(bus1.master), .busy(busy1), .done(done1), .chk_err(chk_err1), .chk_err_cnt(chk_cnt1));

   bram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .BUF_DEPTH(4)) u_dut2 (
      .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .start(start2), .base_addr(base2), .length(len2),
      .bus(bus2.master), .busy(busy2), .done(done2), .chk_err(chk_err2), .chk_err_cnt(chk_cnt2));

   always #5 rd_clk = ~rd_clk;

   always @(posedge rd_clk) bus1.ram_rd_data <= ram[bus1.ram_rd_addr];
   always @(posedge rd_clk) begin
      ram2_stage        <= ram[bus2.ram_rd_addr];
      bus2.ram_rd_data  <= ram2_stage;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   typedef struct {
      int base;
      int len;
      int exp_first;
      int exp_last;
      int exp_end_addr;
   } vec_t;

   // one burst on the latency-1 reader with m_ready held high
   task automatic run_burst1(input int base, input int len, input int exp_first,
                             input int exp_last, input int exp_end_addr);
      int lat, k, guard, bubbles, bad_data, early_last, first_d, last_d, last_f;
      @(negedge rd_clk);
      start1 = 1'b1; base1 = AW'(base); len1 = (AW+1)'(len);
      @(negedge rd_clk);
      start1 = 1'b0;
      check("chk_clear_on_start", chk_err1, 0);
      if (len == 0) begin
         check("zero_len_done", done1, 1);
         check("zero_len_busy", busy1, 0);
         check("zero_len_valid", bus1.m_valid, 0);
         check("zero_len_addr", bus1.ram_rd_addr, exp_end_addr);
         @(negedge rd_clk);
         check("zero_len_done_pulse", done1, 0);
         return;
      end
      check("busy_after_start", busy1, 1);
      lat = 0;
      while (!bus1.m_valid && lat < 20) begin
         @(negedge rd_clk);
         lat++;
      end
      check("first_valid_latency", lat, 2);
      k = 0; guard = 0; bubbles = 0; bad_data = 0; early_last = 0;
      first_d = -1; last_d = -1; last_f = 0;
      while (k < len && guard < len + 50) begin
         if (bus1.m_valid) begin
            if (bus1.m_data != ram[(base + k) % 2048]) bad_data++;
            if (k == 0) first_d = bus1.m_data;
            if (k == len - 1) begin
               last_d = bus1.m_data;
               last_f = bus1.m_last;
            end else if (bus1.m_last) early_last++;
            k++;
         end else bubbles++;
         if (done1) early_last++;
         @(negedge rd_clk);
         guard++;
      end
      check("words_received", k, len);
      check("no_bubbles", bubbles, 0);
      check("data_errors", bad_data, 0);
      check("first_word", first_d, exp_first);
      check("last_word", last_d, exp_last);
      check("last_flag", last_f, 1);
      check("spurious_last_or_done", early_last, 0);
      check("done_after_last", done1, 1);
      check("busy_clear_at_done", busy1, 0);
      check("valid_clear_at_done", bus1.m_valid, 0);
      check("end_addr", bus1.ram_rd_addr, exp_end_addr);
      @(negedge rd_clk);
      check("done_single_pulse", done1, 0);
   endtask

   initial begin
      vec_t vecs[5];
      int k, cyc, guard, cnt, data_bad, hold_bad, last_bad, holds, max_occ;
      logic [DW-1:0] prev_d;
      logic prev_l, prev_stall;
      int rdy_pat[4];

      vecs[0] = '{0,    16,   'hFF, 'hF0, 16};
      vecs[1] = '{2045, 6,    'h02, 'hFD, 3};
      vecs[2] = '{300,  0,    0,    0,    3};
      vecs[3] = '{100,  1,    'h9B, 'h9B, 101};
      vecs[4] = '{0,    2048, 'hFF, 'h00, 0};
      rdy_pat = '{1, 0, 0, 1};

      for (int a = 0; a < 2048; a++) ram[a] = DW'(255 - (a % 256));
      bus1.m_ready = 1'b1;
      bus2.m_ready = 1'b1;

      #1;
      check("rst_valid1", bus1.m_valid, 0);
      check("rst_data1", bus1.m_data, 0);
      check("rst_last1", bus1.m_last, 0);
      check("rst_addr1", bus1.ram_rd_addr, 0);
      check("rst_busy1", busy1, 0);
      check("rst_done1", done1, 0);
      check("rst_chk_err1", chk_err1, 0);
      check("rst_chk_cnt1", chk_cnt1, 0);
      check("rst_valid2", bus2.m_valid, 0);
      repeat (3) @(negedge rd_clk);
      rd_rst_n = 1'b1;

      for (int i = 0; i < 5; i++)
         run_burst1(vecs[i].base, vecs[i].len, vecs[i].exp_first, vecs[i].exp_last, vecs[i].exp_end_addr);

      // start while busy is ignored
      @(negedge rd_clk);
      start1 = 1'b1; base1 = 11'd0; len1 = 12'd4;
      @(negedge rd_clk);
      base1 = 11'd500; len1 = 12'd3;
      @(negedge rd_clk);
      start1 = 1'b0;
      k = 0; guard = 0; data_bad = 0; cnt = 0;
      while (guard < 30) begin
         if (bus1.m_valid) begin
            if (k >= 4 || bus1.m_data != DW'(255 - k)) data_bad++;
            k++;
         end
         if (done1) cnt++;
         @(negedge rd_clk);
         guard++;
      end
      check("busy_start_words", k, 4);
      check("busy_start_data", data_bad, 0);
      check("busy_start_done_count", cnt, 1);

      // latency-2 reader under 1,0,0,1 backpressure
      @(negedge rd_clk);
      start2 = 1'b1; base2 = 11'd0; len2 = 12'd32;
      @(negedge rd_clk);
      start2 = 1'b0;
      k = 0; cyc = 0; data_bad = 0; hold_bad = 0; last_bad = 0; holds = 0; max_occ = 0;
      prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
      while (k < 32 && cyc < 400) begin
         bus2.m_ready = rdy_pat[cyc % 4] != 0;
         if (prev_stall) begin
            holds++;
            if (bus2.m_data != prev_d || bus2.m_last != prev_l) hold_bad++;
         end
         if (int'(u_dut2.count) > max_occ) max_occ = int'(u_dut2.count);
         if (bus2.m_valid && bus2.m_ready) begin
            if (bus2.m_data != DW'(255 - k)) data_bad++;
            if (bus2.m_last != (k == 31)) last_bad++;
            k++;
         end
         prev_stall = bus2.m_valid && !bus2.m_ready;
         prev_d = bus2.m_data;
         prev_l = bus2.m_last;
         @(negedge rd_clk);
         cyc++;
      end
      bus2.m_ready = 1'b1;
      check("bp_words", k, 32);
      check("bp_data_errors", data_bad, 0);
      check("bp_hold_errors", hold_bad, 0);
      check("bp_stalls_seen", holds > 0, 1);
      check("bp_last_errors", last_bad, 0);
      check("bp_fifo_max_le4", max_occ <= 4, 1);
      check("bp_done", done2, 1);
      check("bp_busy_clear", busy2, 0);

      // reset after 5 of 20 words
      @(negedge rd_clk);
      start1 = 1'b1; base1 = 11'd0; len1 = 12'd20;
      @(negedge rd_clk);
      start1 = 1'b0;
      k = 0; guard = 0;
      while (k < 5 && guard < 50) begin
         if (bus1.m_valid) k++;
         @(negedge rd_clk);
         guard++;
      end
      check("rst_mid_pre_words", k, 5);
      rd_rst_n = 1'b0;
      #1;
      check("rst_mid_valid", bus1.m_valid, 0);
      check("rst_mid_data", bus1.m_data, 0);
      check("rst_mid_last", bus1.m_last, 0);
      check("rst_mid_addr", bus1.ram_rd_addr, 0);
      check("rst_mid_busy", busy1, 0);
      check("rst_mid_done", done1, 0);
      @(negedge rd_clk);
      @(negedge rd_clk);
      rd_rst_n = 1'b1;
      cnt = 0;
      repeat (6) begin
         @(negedge rd_clk);
         if (bus1.m_valid || done1 || busy1) cnt++;
      end
      check("rst_mid_quiet_after", cnt, 0);
      run_burst1(0, 4, 'hFF, 'hFC, 4);

      // corrupted word for the pattern checker
      ram[3] = 8'h00;
      run_burst1(0, 8, 'hFF, 'hF8, 8);
      check("chk_err_set", chk_err1, CHK_EXP);
      check("chk_err_cnt", chk_cnt1, CHK_EXP);
      ram[3] = 8'hFC;
      run_burst1(0, 4, 'hFF, 'hFC, 4);
      check("chk_err_clean", chk_err1, 0);
      check("chk_cnt_clean", chk_cnt1, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
